seg7_readback_checker: RTL and testbench
========================================

Name: seg7_readback_checker

Overview:
- Board-side decoder and checker for the whack-a-mole display bus. It is the receive end of the {dp, seg} pad outputs and the score pad outputs.
- Samples and de-glitches the active-low 7-segment pattern, then classifies it as mole position, score digit, blank or invalid.
- Tracks mole moves during play and verifies that the alternating score digits shown after game end match the binary score bus.
- Used on the FPGA test harness and in the system bench as a self-checking monitor.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles a pattern must hold before it is accepted (≥2).
- TIMEOUT_CYCLES, 2048: maximum cycles in score mode before both digits must have been seen.
- TO_W, 12: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, synchronous, active-low. Single clock domain; reset is synchronous and active-low.
- chk_en, input, 1: 1 enables checking; 0 forces IDLE and suppresses all events.
- seg_in, input, 7: active-low segments a..g (bit0=a).
- dp_in, input, 1: 1 = mole mode, 0 = score-display mode.
- score_in, input, 8: binary score bus from the game.
- mole_valid, output, 1: level, high in MOLE state.
- mole_idx, output, 3: last accepted mole segment index.
- mole_changes, output, 8: count of accepted mole moves, saturates at 255.
- digit_valid, output, 1: one-cycle pulse per accepted score-mode pattern.
- digit, output, 4: decoded digit 0-9, or 4'hF for blank.
- score_ok, output, 1: one-cycle pulse when both expected digits have been seen.
- score_err, output, 1: one-cycle pulse on any error.
- err_code, output, 2: last error. 01 = digit mismatch, 10 = timeout, 11 = invalid pattern. Holds until the next error.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, sample register 0, stability counter 0.
- Input stage: {dp_in, seg_in} is registered every cycle. The stability counter resets when the sample differs from the previous sample, otherwise increments and saturates.
- Acceptance: a sample is accepted when it has been present for STABLE_CYCLES consecutive cycles and differs from the last accepted pattern. Each distinct pattern is accepted once. Outputs update on the edge after acceptance.
- Worst-case latency from the input change to the output: STABLE_CYCLES+1 clocks.
- Classification of an accepted pattern:
  - dp=1 with exactly one seg bit 0: MOLE, idx = position of that bit.
  - dp=0 with seg matching the standard active-low 0-9 table (0=1000000 ... 9=0010000): DIGIT.
  - dp=0 with seg=1111111: DIGIT F (blank).
  - dp=1 with seg=1111111: BLANK, ignored.
  - Anything else: INVALID.
- INVALID in any state: score_err pulse, err_code=11, state unchanged.
- Expected digits: ones=score_in%10 and tens=score_in/10, latched on entry to SCORE_WAIT. If score_in ≥100, the expected tens is F (blank).
- FSM states are IDLE, MOLE, SCORE_WAIT, SCORE_DONE.
  - IDLE, MOLE accepted: go to MOLE, mole_idx=idx, mole_changes=0.
  - IDLE, DIGIT accepted: go to SCORE_WAIT, then evaluate that digit.
  - MOLE, MOLE accepted with idx ≠ mole_idx: update mole_idx, mole_changes+1 (saturating).
  - MOLE, DIGIT accepted: go to SCORE_WAIT, clear the seen flags, load the timeout, latch expected digits, then evaluate the digit.
  - SCORE_WAIT, digit accepted: the digit sets ones_seen if equal to ones, and tens_seen if equal to tens (both if equal). Otherwise score_err pulse, err_code=01. When both flags are set: score_ok pulse, go to SCORE_DONE.
  - SCORE_WAIT, timeout: on reaching TIMEOUT_CYCLES, score_err pulse, err_code=10, go to SCORE_DONE.
  - SCORE_DONE: digits are still compared against the latched expected pair; a mismatch gives err_code=01. MOLE accepted: new game, go to MOLE, mole_changes=0.
- Every accepted DIGIT pulses digit_valid with digit set to the decoded value.
- Simultaneous events: if a completing digit arrives in the timeout cycle, score_ok wins and no timeout error is raised.
- chk_en=0: the filter keeps running, the state is forced to IDLE, mole_valid=0 and no pulses are issued. Counters and err_code hold.
- mole_changes saturates at 255 and does not wrap.
- rst_n low mid-operation: full reset on the next edge. A partial score check is discarded.

Test Plan:
1. Mole tracking: chk_en=1, {dp,seg}=1_1111110 for 10 cycles, then 1_1011111 → mole_valid=1, mole_idx 0 then 5, mole_changes 0 then 1.
2. Glitch rejection: a pattern held 3 cycles then reverted (STABLE_CYCLES=4) → no acceptance, mole_idx unchanged, no pulses.
3. Correct score check: score_in=42, alternate dp=0 seg 0100100 (2) and 0011001 (4), 20 cycles each → digit_valid pulses with digit 2 then 4, exactly one score_ok, state SCORE_DONE.
4. Mismatch then timeout: score_in=42, display 2 then 7 → score_err with err_code=01; no 4 ever shown → score_err with err_code=10 at TIMEOUT_CYCLES, no score_ok.
5. Three-digit score: score_in=105, display 5 and blank (dp=0, seg=1111111) → digit 5 and F accepted, score_ok pulse.
6. Invalid pattern and reset: dp=1 seg=1111100 → err_code=11. Then, in SCORE_WAIT, rst_n=0 for 1 cycle → all outputs 0 next edge, state IDLE.

Source files
------------

// File: rtl/seg7_readback_checker_if.sv
// Display-bus monitor signals: pad-side drive in,
// classification and score-check results out.
interface seg7_readback_checker_if;
  logic       chk_en;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [7:0] score_in;
  logic       mole_valid;
  logic [2:0] mole_idx;
  logic [7:0] mole_changes;
  logic       digit_valid;
  logic [3:0] digit;
  logic       score_ok;
  logic       score_err;
  logic [1:0] err_code;

  modport master (
    output chk_en, seg_in, dp_in, score_in,
    input  mole_valid, mole_idx, mole_changes,
    input  digit_valid, digit, score_ok,
    input  score_err, err_code
  );

  modport slave (
    input  chk_en, seg_in, dp_in, score_in,
    output mole_valid, mole_idx, mole_changes,
    output digit_valid, digit, score_ok,
    output score_err, err_code
  );
endinterface

// File: rtl/seg7_readback_checker.sv
// De-glitches the {dp,seg} display bus, classifies each
// stable pattern and checks mole moves / score digits.
module seg7_readback_checker #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter int unsigned TO_W           = 12
) (
  input logic                    clk,
  input logic                    rst_n,
  seg7_readback_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, MOLE, SCORE_WAIT, SCORE_DONE
  } state_e;

  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] ST_MAX =
    SW'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX =
    TO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]      pin;
  logic [7:0]      samp_q, acc_q, acc_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic            accept;
  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      chg_q, chg_d;
  logic            dv_q, dv_d;
  logic [3:0]      dig_q, dig_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [3:0]      eo_q, eo_d, et_q, et_d;
  logic            so_q, so_d, st_q, st_d;
  logic [TO_W-1:0] to_q, to_d;

  logic [6:0] seg;
  logic       dp;
  logic       is_mole, is_dig, is_blank, is_inv;
  logic       d_ok, m_o, m_t;
  logic [2:0] m_idx;
  logic [3:0] d_val;
  logic [3:0] ones_n, tens_n;

  assign pin = {bus.dp_in, bus.seg_in};

  always_comb begin
    stab_d = stab_q;
    if (pin != samp_q) begin
      stab_d = '0;
    end else if (stab_q != ST_MAX) begin
      stab_d = stab_q + 1'b1;
    end
  end

  // Each distinct stable pattern fires exactly once.
  assign accept = (stab_q == ST_MAX) &&
                  (samp_q != acc_q);
  assign acc_d  = accept ? samp_q : acc_q;

  assign {dp, seg} = samp_q;

  always_comb begin
    m_idx = '0;
    for (int i = 0; i < 7; i++) begin
      if (!seg[i]) m_idx = 3'(i);
    end
  end

  always_comb begin
    d_ok  = 1'b1;
    d_val = 4'hF;
    case (seg)
      7'h40:   d_val = 4'd0;
      7'h79:   d_val = 4'd1;
      7'h24:   d_val = 4'd2;
      7'h30:   d_val = 4'd3;
      7'h19:   d_val = 4'd4;
      7'h12:   d_val = 4'd5;
      7'h02:   d_val = 4'd6;
      7'h78:   d_val = 4'd7;
      7'h00:   d_val = 4'd8;
      7'h10:   d_val = 4'd9;
      7'h7F:   d_val = 4'hF;
      default: d_ok  = 1'b0;
    endcase
  end

  assign is_mole  = dp && ($countones(~seg) == 1);
  assign is_dig   = !dp && d_ok;
  assign is_blank = dp && (seg == 7'h7F);
  assign is_inv   = !(is_mole || is_dig || is_blank);

  assign ones_n = 4'(bus.score_in % 8'd10);
  assign tens_n = (bus.score_in >= 8'd100) ? 4'hF :
                  4'(bus.score_in / 8'd10);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chg_d   = chg_q;
    dv_d    = 1'b0;
    dig_d   = dig_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    eo_d    = eo_q;
    et_d    = et_q;
    so_d    = so_q;
    st_d    = st_q;
    to_d    = to_q;
    m_o     = 1'b0;
    m_t     = 1'b0;
    if (!bus.chk_en) begin
      state_d = IDLE;
    end else begin
      if (state_q == SCORE_WAIT) to_d = to_q + 1'b1;
      if (accept) begin
        unique case (1'b1)
          is_inv: begin
            err_d  = 1'b1;
            code_d = 2'b11;
          end
          is_mole: begin
            unique case (state_q)
              IDLE, SCORE_DONE: begin
                state_d = MOLE;
                idx_d   = m_idx;
                chg_d   = '0;
              end
              MOLE: begin
                if (m_idx != idx_q) begin
                  idx_d = m_idx;
                  if (chg_q != 8'hFF) chg_d = chg_q + 8'd1;
                end
              end
              default: ;
            endcase
          end
          is_dig: begin
            dv_d  = 1'b1;
            dig_d = d_val;
            if (state_q == IDLE || state_q == MOLE) begin
              state_d = SCORE_WAIT;
              eo_d    = ones_n;
              et_d    = tens_n;
              so_d    = 1'b0;
              st_d    = 1'b0;
              to_d    = '0;
            end
            m_o = (d_val == eo_d);
            m_t = (d_val == et_d);
            if (!(m_o || m_t)) begin
              err_d  = 1'b1;
              code_d = 2'b01;
            end
            if (state_d == SCORE_WAIT) begin
              so_d = so_d | m_o;
              st_d = st_d | m_t;
              if (so_d && st_d) begin
                ok_d    = 1'b1;
                state_d = SCORE_DONE;
              end
            end
          end
          default: ;
        endcase
      end
      // A completing digit in the last cycle beats the timeout.
      if (state_q == SCORE_WAIT &&
          state_d == SCORE_WAIT && to_q == TO_MAX) begin
        err_d   = 1'b1;
        code_d  = 2'b10;
        state_d = SCORE_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q  <= '0;
      acc_q   <= '0;
      stab_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      chg_q   <= '0;
      dv_q    <= 1'b0;
      dig_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      eo_q    <= '0;
      et_q    <= '0;
      so_q    <= 1'b0;
      st_q    <= 1'b0;
      to_q    <= '0;
    end else begin
      samp_q  <= pin;
      acc_q   <= acc_d;
      stab_q  <= stab_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      chg_q   <= chg_d;
      dv_q    <= dv_d;
      dig_q   <= dig_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      eo_q    <= eo_d;
      et_q    <= et_d;
      so_q    <= so_d;
      st_q    <= st_d;
      to_q    <= to_d;
    end
  end

  assign bus.mole_valid   = (state_q == MOLE);
  assign bus.mole_idx     = idx_q;
  assign bus.mole_changes = chg_q;
  assign bus.digit_valid  = dv_q;
  assign bus.digit        = dig_q;
  assign bus.score_ok     = ok_q;
  assign bus.score_err    = err_q;
  assign bus.err_code     = code_q;

endmodule

// File: tb/tb_seg7_readback_checker.sv
// Directed + randomized bench for the display readback
// checker against an accepted-pattern event model.
module tb_seg7_readback_checker;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 2048;

  localparam logic [6:0] SEGT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic clk;
  logic rst_n;

  seg7_readback_checker_if bus ();

  seg7_readback_checker #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TO_W           (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad;
  int n_dv, n_ok, n_err, cyc, t_dv, t_to;
  bit to_seen;

  always @(negedge clk) begin
    cyc++;
    if (bus.digit_valid) begin
      n_dv++;
      t_dv = cyc;
    end
    if (bus.score_ok) n_ok++;
    if (bus.score_err) begin
      n_err++;
      if (bus.err_code == 2'b10) begin
        t_to    = cyc;
        to_seen = 1'b1;
      end
    end
  end

  // Model: 0 idle, 1 mole, 2 score wait, 3 score done
  int         m_state, m_idx, m_chg, m_code, m_dig;
  int         m_eo, m_et, m_score;
  bit         m_so, m_st, m_en;
  logic [7:0] m_acc;
  int         e_dv, e_ok, e_err;

  function automatic void m_reset();
    m_state = 0;
    m_idx   = 0;
    m_chg   = 0;
    m_code  = 0;
    m_dig   = 0;
    m_so    = 0;
    m_st    = 0;
    m_acc   = 8'h00;
  endfunction

  function automatic void m_accept(input logic [7:0] p);
    int zeros, zi, d;
    logic [6:0] s;
    if (p == m_acc) return;
    m_acc = p;
    if (!m_en) return;
    s     = p[6:0];
    zeros = 0;
    zi    = 0;
    for (int i = 0; i < 7; i++) begin
      if (!s[i]) begin
        zeros++;
        zi = i;
      end
    end
    d = -1;
    for (int k = 0; k < 10; k++) begin
      if (s == SEGT[k]) d = k;
    end
    if (s == 7'h7F) d = 15;
    if (p[7] && zeros == 1) begin
      if (m_state == 0 || m_state == 3) begin
        m_state = 1;
        m_idx   = zi;
        m_chg   = 0;
      end else if (m_state == 1 && zi != m_idx) begin
        m_idx = zi;
        if (m_chg < 255) m_chg++;
      end
    end else if (!p[7] && d >= 0) begin
      e_dv++;
      m_dig = d;
      if (m_state <= 1) begin
        m_state = 2;
        m_eo    = m_score % 10;
        m_et    = (m_score >= 100) ? 15 : m_score / 10;
        m_so    = 0;
        m_st    = 0;
      end
      if (d != m_eo && d != m_et) begin
        e_err++;
        m_code = 1;
      end
      if (m_state == 2) begin
        if (d == m_eo) m_so = 1;
        if (d == m_et) m_st = 1;
        if (m_so && m_st) begin
          e_ok++;
          m_state = 3;
        end
      end
    end else if (!(p[7] && zeros == 0)) begin
      e_err++;
      m_code = 3;
    end
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mole_valid", 32'(bus.mole_valid),
        32'(m_state == 1));
    chk("mole_idx", 32'(bus.mole_idx), m_idx);
    chk("mole_changes", 32'(bus.mole_changes), m_chg);
    chk("err_code", 32'(bus.err_code), m_code);
    chk("digit", 32'(bus.digit), m_dig);
    chk("digit_valid_cnt", n_dv, e_dv);
    chk("score_ok_cnt", n_ok, e_ok);
    chk("score_err_cnt", n_err, e_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mv"}, 32'(bus.mole_valid), 0);
    chk({tag, "_idx"}, 32'(bus.mole_idx), 0);
    chk({tag, "_chg"}, 32'(bus.mole_changes), 0);
    chk({tag, "_dv"}, 32'(bus.digit_valid), 0);
    chk({tag, "_dig"}, 32'(bus.digit), 0);
    chk({tag, "_ok"}, 32'(bus.score_ok), 0);
    chk({tag, "_err"}, 32'(bus.score_err), 0);
    chk({tag, "_code"}, 32'(bus.err_code), 0);
  endtask

  task automatic drive(input logic [7:0] p,
                       input int n);
    bus.dp_in  = p[7];
    bus.seg_in = p[6:0];
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic step(input logic [7:0] p,
                      input int n);
    drive(p, n);
    m_accept(p);
    check_all();
  endtask

  function automatic logic [7:0] mp(input int i);
    return {1'b1, ~(7'b0000001 << i)};
  endfunction

  function automatic logic [7:0] dg(input int k);
    if (k == 15) return 8'h7F;
    return {1'b0, SEGT[k]};
  endfunction

  task automatic set_score(input int s);
    bus.score_in = 8'(s);
    m_score      = s;
  endtask

  function automatic logic [7:0] rnd_pat(input bit score_ph);
    int r;
    r = int'($urandom_range(0, 9));
    if (!score_ph) begin
      if (r < 7) return mp(int'($urandom_range(0, 6)));
      if (r < 8) return 8'hFF;
      return 8'($urandom);
    end
    if (r < 6) return dg(int'($urandom_range(0, 9)));
    if (r < 7) return 8'h7F;
    return 8'($urandom);
  endfunction

  initial begin
    int t_entry, sc, nm;
    rst_n      = 1'b0;
    bus.chk_en = 1'b1;
    m_en       = 1'b1;
    bus.dp_in  = 1'b1;
    bus.seg_in = 7'h7F;
    set_score(0);
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Mole tracking with exact acceptance latency
    step(mp(0), 10);
    drive(mp(5), STABLE);
    chk("lat_before", 32'(bus.mole_idx), 0);
    drive(mp(5), 1);
    chk("lat_after", 32'(bus.mole_idx), 5);
    m_accept(mp(5));
    drive(mp(5), 4);
    check_all();

    // Glitch held STABLE-1 cycles is dropped
    drive(mp(2), STABLE - 1);
    step(mp(5), 8);

    // Correct score 42, alternating digits
    set_score(42);
    for (int r = 0; r < 3; r++) begin
      step(dg(2), 20);
      step(dg(4), 20);
    end

    // Mismatch, then timeout
    step(mp(3), 8);
    step(dg(2), 8);
    t_entry = t_dv;
    step(dg(7), 8);
    to_seen = 1'b0;
    for (int k = 0; k < TIMEOUT + 200; k++) begin
      if (to_seen) break;
      @(negedge clk);
    end
    #1;
    chk("timeout_seen", 32'(to_seen), 1);
    chk("timeout_delay", t_to - t_entry, TIMEOUT);
    m_state = 3;
    m_code  = 2;
    e_err++;
    check_all();

    // Three-digit score: tens shown blank
    step(mp(4), 8);
    set_score(105);
    step(dg(5), 20);
    step(dg(15), 20);

    // Disabled checker: no events, forced idle
    bus.chk_en = 1'b0;
    m_en       = 1'b0;
    m_state    = 0;
    step(mp(6), 8);
    step(dg(3), 8);
    bus.chk_en = 1'b1;
    m_en       = 1'b1;
    step(mp(1), 8);

    // Saturation of mole_changes
    for (int k = 0; k < 260; k++) begin
      drive(mp(2 + (k % 2)), STABLE + 1);
      m_accept(mp(2 + (k % 2)));
    end
    check_all();

    // Invalid pattern, then reset mid score check
    step(8'hFC, 8);
    step(dg(1), 8);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_zero("midrst");
    rst_n = 1'b1;
    m_reset();
    step(mp(2), 8);

    // Randomized games
    for (int g = 0; g < 6; g++) begin
      sc = int'($urandom_range(0, 255));
      set_score(sc);
      step(mp(int'($urandom_range(0, 6))), 8);
      nm = int'($urandom_range(3, 8));
      for (int k = 0; k < nm; k++) begin
        if ($urandom_range(0, 3) == 0)
          drive(rnd_pat(1'b0),
                int'($urandom_range(1, STABLE - 1)));
        step(rnd_pat(1'b0),
             int'($urandom_range(STABLE + 1, 12)));
      end
      nm = int'($urandom_range(3, 8));
      for (int k = 0; k < nm; k++) begin
        if ($urandom_range(0, 3) == 0)
          drive(rnd_pat(1'b1),
                int'($urandom_range(1, STABLE - 1)));
        step(rnd_pat(1'b1),
             int'($urandom_range(STABLE + 1, 12)));
      end
      step(dg(sc % 10), 10);
      step(dg(sc >= 100 ? 15 : sc / 10), 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
